// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX fields and hazard status out.
// master drives the ID side; slave is the pipeline stage itself.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic [31:0] id_imm_ext;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic        id_memtoreg;
    logic        id_alusrc;
    logic        id_regdst;
    logic        id_branch;
    logic [1:0]  id_aluop;
    logic        hold;
    logic        flush;

    logic        hazard_stall;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dst;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_alusrc;
    logic        ex_branch;
    logic [1:0]  ex_aluop;
    logic [15:0] bubble_count;

    modport master (
        output id_valid, id_instr, id_pc_plus4, id_rd1, id_rd2, id_imm_ext,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
               id_regdst, id_branch, id_aluop, hold, flush,
        input  hazard_stall, ex_valid, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
               ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alusrc, ex_branch, ex_aluop, bubble_count
    );

    modport slave (
        input  id_valid, id_instr, id_pc_plus4, id_rd1, id_rd2, id_imm_ext,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
               id_regdst, id_branch, id_aluop, hold, flush,
        output hazard_stall, ex_valid, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
               ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alusrc, ex_branch, ex_aluop, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection; 1-cycle latency, combinational hazard_stall.
// Backpressure: hold freezes the register; hazard_stall asks PC and IF/ID to hold for one bubble.
module id_ex_stage (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        branch;
        logic [1:0]  aluop;
    } ex_t;

    ex_t         ex_q;
    ex_t         ex_cap;
    logic [15:0] bubble_cnt;
    logic [5:0]  opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        uses_rt;
    logic        hazard;
    logic        unused_funct;

    assign opcode       = bus.id_instr[31:26];
    assign id_rs        = bus.id_instr[25:21];
    assign id_rt        = bus.id_instr[20:16];
    assign id_rd        = bus.id_instr[15:11];
    assign unused_funct = ^bus.id_instr[10:0];

    // R-type, sw, beq and bne read rt as a source; everything else treats it as a destination.
    assign uses_rt = (opcode == 6'h00) | (opcode == 6'h2B) |
                     (opcode == 6'h04) | (opcode == 6'h05);

    assign hazard = ~bus.flush & bus.id_valid & ex_q.valid & ex_q.memread &
                    (ex_q.rt != 5'd0) &
                    ((ex_q.rt == id_rs) | (uses_rt & (ex_q.rt == id_rt)));

    assign bus.hazard_stall = hazard;

    always_comb begin
        ex_cap          = '0;
        ex_cap.valid    = bus.id_valid;
        ex_cap.pc_plus4 = bus.id_pc_plus4;
        ex_cap.rd1      = bus.id_rd1;
        ex_cap.rd2      = bus.id_rd2;
        ex_cap.imm      = bus.id_imm_ext;
        ex_cap.rs       = id_rs;
        ex_cap.rt       = id_rt;
        ex_cap.dst      = bus.id_regdst ? id_rd : id_rt;
        // A non-valid slot keeps its fields but must never write state.
        ex_cap.regwrite = bus.id_valid & bus.id_regwrite;
        ex_cap.memread  = bus.id_valid & bus.id_memread;
        ex_cap.memwrite = bus.id_valid & bus.id_memwrite;
        ex_cap.memtoreg = bus.id_valid & bus.id_memtoreg;
        ex_cap.alusrc   = bus.id_valid & bus.id_alusrc;
        ex_cap.branch   = bus.id_valid & bus.id_branch;
        ex_cap.aluop    = bus.id_valid ? bus.id_aluop : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            bubble_cnt <= 16'd0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (!bus.hold) begin
            if (hazard) begin
                ex_q <= '0;
                if (bubble_cnt != 16'hFFFF) begin
                    bubble_cnt <= bubble_cnt + 16'd1;
                end
            end else begin
                ex_q <= ex_cap;
            end
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc_plus4  = ex_q.pc_plus4;
    assign bus.ex_rd1       = ex_q.rd1;
    assign bus.ex_rd2       = ex_q.rd2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_dst       = ex_q.dst;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.bubble_count = bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against an instruction-level model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0]  LW_CTL = 7'b1101100; // regwrite memread memwrite memtoreg alusrc regdst branch
    localparam logic [6:0]  R_CTL  = 7'b1000010;
    localparam logic [6:0]  I_CTL  = 7'b1000100;
    localparam logic [31:0] LW9    = {6'h23, 5'd1, 5'd9, 16'h0000};
    localparam logic [31:0] LW0    = {6'h23, 5'd1, 5'd0, 16'h0000};
    localparam logic [31:0] ADD    = 32'h012A4020;
    localparam logic [31:0] ADD0   = {6'h00, 5'd0, 5'd0, 5'd8, 11'h020};
    localparam logic [31:0] ADDI99 = {6'h08, 5'd9, 5'd9, 16'h0001};
    localparam logic [31:0] ADDI82 = {6'h08, 5'd2, 5'd8, 16'h0001};

    typedef struct {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, dst;
        logic        regwrite, memread, memwrite, memtoreg, alusrc, branch;
        logic [1:0]  aluop;
    } ex_m_t;

    ex_m_t m;
    ex_m_t nx;
    int    m_cnt;
    int    nx_cnt;
    int    cnt_before;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what EX should contain after one instruction-level step.
    function automatic logic model_stall();
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       reads_rt;
        op = bus.id_instr[31:26];
        rs = bus.id_instr[25:21];
        rt = bus.id_instr[20:16];
        reads_rt = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
        if (bus.flush || !bus.id_valid || !m.valid || !m.memread || m.rt == 5'd0) return 1'b0;
        return (m.rt == rs) || (reads_rt && m.rt == rt);
    endfunction

    task automatic model_next();
        nx = m;
        nx_cnt = m_cnt;
        if (bus.flush) begin
            nx = '{default: 0};
        end else if (bus.hold) begin
            nx = m;
        end else if (model_stall()) begin
            nx = '{default: 0};
            nx_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else begin
            nx.valid    = bus.id_valid;
            nx.pc       = bus.id_pc_plus4;
            nx.rd1      = bus.id_rd1;
            nx.rd2      = bus.id_rd2;
            nx.imm      = bus.id_imm_ext;
            nx.rs       = bus.id_instr[25:21];
            nx.rt       = bus.id_instr[20:16];
            nx.dst      = bus.id_regdst ? bus.id_instr[15:11] : bus.id_instr[20:16];
            nx.regwrite = bus.id_valid && bus.id_regwrite;
            nx.memread  = bus.id_valid && bus.id_memread;
            nx.memwrite = bus.id_valid && bus.id_memwrite;
            nx.memtoreg = bus.id_valid && bus.id_memtoreg;
            nx.alusrc   = bus.id_valid && bus.id_alusrc;
            nx.branch   = bus.id_valid && bus.id_branch;
            nx.aluop    = bus.id_valid ? bus.id_aluop : 2'b00;
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid", 128'(bus.ex_valid), 128'(m.valid));
        chk("ex_ctrl", 128'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg,
                             bus.ex_alusrc, bus.ex_branch, bus.ex_aluop}),
                       128'({m.regwrite, m.memread, m.memwrite, m.memtoreg,
                             m.alusrc, m.branch, m.aluop}));
        chk("ex_data", {bus.ex_pc_plus4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm},
                       {m.pc, m.rd1, m.rd2, m.imm});
        chk("ex_spec", 128'({bus.ex_rs, bus.ex_rt, bus.ex_dst}), 128'({m.rs, m.rt, m.dst}));
        chk("bubble_count", 128'(bus.bubble_count), 128'(m_cnt[15:0]));
    endtask

    task automatic step();
        #1;
        chk("hazard_stall", 128'(bus.hazard_stall), 128'(model_stall()));
        model_next();
        @(posedge clk);
        #1;
        m = nx;
        m_cnt = nx_cnt;
        check_outputs();
    endtask

    task automatic put(input logic [31:0] instr, input logic [6:0] ctl, input logic [1:0] aluop);
        bus.id_valid    = 1'b1;
        bus.id_instr    = instr;
        bus.id_pc_plus4 = $urandom;
        bus.id_rd1      = $urandom;
        bus.id_rd2      = $urandom;
        bus.id_imm_ext  = $urandom;
        {bus.id_regwrite, bus.id_memread, bus.id_memwrite, bus.id_memtoreg,
         bus.id_alusrc, bus.id_regdst, bus.id_branch} = ctl;
        bus.id_aluop    = aluop;
        bus.hold        = 1'b0;
        bus.flush       = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd2;
            3:       return 5'd9;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic rand_inputs();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0:       op = 6'h00;
            1:       op = 6'h23;
            2:       op = 6'h2B;
            3:       op = 6'h04;
            4:       op = 6'h05;
            5:       op = 6'h08;
            default: op = 6'($urandom);
        endcase
        put({op, pick_reg(), pick_reg(), pick_reg(), 11'($urandom)}, 7'($urandom), 2'($urandom));
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.hold     = ($urandom_range(0, 9) == 0);
        bus.flush    = ($urandom_range(0, 11) == 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs toggling underneath.
        rst_n = 1'b0;
        m = '{default: 0};
        m_cnt = 0;
        repeat (3) begin
            rand_inputs();
            @(posedge clk);
        end
        #2;
        chk("rst_stall", 128'(bus.hazard_stall), 128'(0));
        check_outputs();
        rst_n = 1'b1;
        #1;
        check_outputs();

        // Plain capture of add $8,$9,$10.
        put(ADD, R_CTL, 2'b10);
        bus.id_rd1 = 32'd5;
        bus.id_rd2 = 32'd7;
        bus.id_imm_ext = 32'h0000_4020;
        step();
        chk("cap_rs", 128'(bus.ex_rs), 128'(9));
        chk("cap_rt", 128'(bus.ex_rt), 128'(10));
        chk("cap_dst", 128'(bus.ex_dst), 128'(8));
        chk("cap_rd1", 128'(bus.ex_rd1), 128'(5));
        chk("cap_regwrite", 128'(bus.ex_regwrite), 128'(1));

        // Load-use: one stall cycle, one bubble, then the add proceeds.
        put(LW9, LW_CTL, 2'b00);
        step();
        put(ADD, R_CTL, 2'b10);
        #1;
        chk("lu_stall", 128'(bus.hazard_stall), 128'(1));
        step();
        chk("lu_bubble_valid", 128'(bus.ex_valid), 128'(0));
        chk("lu_count", 128'(bus.bubble_count), 128'(1));
        chk("lu_stall_drop", 128'(bus.hazard_stall), 128'(0));
        step();
        chk("lu_add_dst", 128'(bus.ex_dst), 128'(8));
        chk("lu_add_valid", 128'(bus.ex_valid), 128'(1));

        // No false hazards.
        put(LW0, LW_CTL, 2'b00);
        step();
        put(ADD0, R_CTL, 2'b10);
        #1;
        chk("nf_zero_reg", 128'(bus.hazard_stall), 128'(0));
        step();
        put(LW9, LW_CTL, 2'b00);
        step();
        put(ADDI99, I_CTL, 2'b00);
        #1;
        chk("nf_addi_rs", 128'(bus.hazard_stall), 128'(1));
        step();
        step();
        put(LW9, LW_CTL, 2'b00);
        step();
        put(ADDI82, I_CTL, 2'b00);
        #1;
        chk("nf_addi_other", 128'(bus.hazard_stall), 128'(0));
        step();

        // flush + hold + hazard together: flush wins, count unchanged.
        put(LW9, LW_CTL, 2'b00);
        step();
        cnt_before = m_cnt;
        put(ADD, R_CTL, 2'b10);
        bus.flush = 1'b1;
        bus.hold  = 1'b1;
        #1;
        chk("pri_flush_mask", 128'(bus.hazard_stall), 128'(0));
        step();
        chk("pri_bubble", 128'(bus.ex_valid), 128'(0));
        chk("pri_count", 128'(bus.bubble_count), 128'(cnt_before));

        // Hazard under hold for 3 cycles, then exactly one bubble.
        put(LW9, LW_CTL, 2'b00);
        step();
        put(ADD, R_CTL, 2'b10);
        bus.hold = 1'b1;
        repeat (3) begin
            #1;
            chk("hold_stall", 128'(bus.hazard_stall), 128'(1));
            step();
            chk("hold_frozen_rt", 128'(bus.ex_rt), 128'(9));
        end
        bus.hold = 1'b0;
        step();
        chk("hold_release_count", 128'(bus.bubble_count), 128'(cnt_before + 1));
        chk("hold_release_bubble", 128'(bus.ex_valid), 128'(0));

        // Asynchronous reset in the middle of a stall.
        put(LW9, LW_CTL, 2'b00);
        step();
        put(ADD, R_CTL, 2'b10);
        #1;
        chk("mid_stall_before", 128'(bus.hazard_stall), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_stall_reset", 128'(bus.hazard_stall), 128'(0));
        m = '{default: 0};
        m_cnt = 0;
        check_outputs();
        rst_n = 1'b1;

        // Saturation: preload the counter near the top, then keep generating load-use bubbles.
        force dut.bubble_cnt = 16'hFFFC;
        #1;
        release dut.bubble_cnt;
        m_cnt = 32'h0000_FFFC;
        chk("sat_preload", 128'(bus.bubble_count), 128'(16'hFFFC));
        repeat (5) begin
            put(LW9, LW_CTL, 2'b00);
            step();
            put(ADD, R_CTL, 2'b10);
            step();
        end
        chk("sat_top", 128'(bus.bubble_count), 128'(16'hFFFF));

        // Randomized traffic.
        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the 32-bit MIPS datapath. It registers the decoded control bits, register-file read data, the 32-bit immediate produced by the 16-to-32 sign extender, and the register specifiers into the ID/EX pipeline register. It also detects load-use hazards against the instruction currently in EX and inserts a bubble when one is found. A saturating counter records how many bubbles have been inserted.

## Interface
- No parameters; all widths fixed (32-bit data, 5-bit register specifiers).
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  IF/ID holds a real instruction
- id_instr  input  32  instruction word from IF/ID (opcode [31:26], rs [25:21], rt [20:16], rd [15:11])
- id_pc_plus4  input  32  PC+4 of the ID instruction
- id_rd1, id_rd2  input  32 each  register-file read data for rs and rt
- id_imm_ext  input  32  sign-extended immediate from the sign extender
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst, id_branch  input  1 each  decoded control
- id_aluop  input  2  ALU operation class
- hold  input  1  freeze ID/EX (downstream multi-cycle stall)
- flush  input  1  squash the ID instruction (branch taken in EX)
- hazard_stall  output  1  combinational; holds the PC and IF/ID this cycle
- ex_valid  output  1  registered; EX holds a real instruction
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm  output  32 each  registered datapath
- ex_rs, ex_rt, ex_dst  output  5 each  registered specifiers; ex_dst = id_regdst ? rd : rt
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  output  1 each  registered control
- ex_aluop  output  2  registered
- bubble_count  output  16  saturating count of load-use bubbles

## Operation
- uses_rt = 1 when opcode is 0x00, 0x2B, 0x04 or 0x05; otherwise 0.
- hazard_stall = id_valid & ex_valid & ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- hazard_stall is forced to 0 while flush = 1. It is not masked by hold.
- Next-state priority on each rising edge, highest first:
  1. flush: load a bubble.
  2. hold: all ex_* and bubble_count keep their values.
  3. hazard_stall: load a bubble and increment bubble_count.
  4. Otherwise capture: every ex_* takes its id_* counterpart, and ex_valid = id_valid.
- Bubble: ex_valid and all control outputs = 0; ex_aluop = 0; all datapath outputs and specifiers = 0.
- When id_valid = 0 on a capture cycle, the fields are still captured but all control outputs are forced to 0. This means a non-valid instruction never writes a register or memory.
- bubble_count increments by 1 per inserted load-use bubble and saturates at 0xFFFF. Flush bubbles are not counted.
- Reset (rst_n = 0, asynchronous): every registered output = 0, including bubble_count. The block comes out of reset presenting a bubble. Asserting reset mid-stall clears the stall immediately, because ex_memread = 0.

## Timing
- Latency of 1 cycle from ID inputs to ex_* outputs.
- hazard_stall is valid in the same cycle as the ID inputs. It depends only on registered EX state and the current ID fields, so there is no path from hold or flush into its compare logic other than the flush mask.
- A load-use hazard produces exactly one bubble:
  - Cycle N: the load is in EX and the dependent instruction is in ID, so hazard_stall = 1.
  - Cycle N+1: EX holds the bubble and ex_memread = 0, so hazard_stall = 0 and the dependent instruction is captured at the end of N+1.
- With hold asserted through a hazard, hazard_stall stays at 1 every held cycle and bubble_count does not change. The bubble is inserted on the first edge where hold = 0.
- flush and hazard_stall in the same cycle: flush wins, a bubble is loaded, and the count is unchanged.

## Test plan
- Reset: hold rst_n = 0 with random inputs asserted → all outputs 0, bubble_count = 0, hazard_stall = 0. Release reset on a non-edge → outputs remain 0 until the next capture.
- Plain capture: id_instr = 0x012A4020 (add $8,$9,$10), id_regdst = 1, id_regwrite = 1, id_rd1 = 5, id_rd2 = 7, id_imm_ext = 0x00004020 → after one edge: ex_rs = 9, ex_rt = 10, ex_dst = 8, ex_rd1 = 5, ex_regwrite = 1, ex_valid = 1.
- Load-use: lw $9,0($1) followed by add $8,$9,$10 → hazard_stall = 1 for exactly one cycle, then one bubble with ex_valid = 0. bubble_count goes 0 → 1, and the add reaches EX one edge later.
- No false hazard:
  - lw $0 followed by a use of $0 → hazard_stall = 0.
  - lw $9 followed by addi $9,$9,1, where the addi's rt = 9 but uses_rt = 0 and rs = 9 → hazard_stall = 1.
  - lw $9 followed by addi $8,$2,1 → hazard_stall = 0.
- Priority: hazard, flush and hold asserted together → bubble, count unchanged. Hazard plus hold for 3 cycles → outputs frozen, hazard_stall = 1 throughout, then one bubble and the count increments by 1.
- Saturation: force 65 540 load-use hazards → bubble_count stops at 0xFFFF.
